nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 112 +++++++++++
 tb/tb_nibble_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder/subtractor that time-shares an external 4-bit ripple adder,
// processing one nibble per RUN cycle from LSB to MSB.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Adder port drive; the adder is idle (all zero) outside RUN
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[{idx, 2'b00} +: 4];
      add_b   = b_reg[{idx, 2'b00} +: 4];
      add_cin = carry_reg;
    end
  end

  // Operand capture and per-nibble result accumulation.
  // Subtraction is folded in at accept time as a + ~b + 1, so RUN is mode-agnostic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub | cin;
            idx       <= '0;
          end
        end
        RUN: begin
          sum[{idx, 2'b00} +: 4] <= add_sum;
          carry_reg              <= add_cout;
          if (idx == LAST_IDX) begin
            idx  <= '0;
            cout <= add_cout;
            ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_sum[3] != a_reg[WIDTH-1]);
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed vectors, backpressure,
// mid-operation reset, randomized operations and adder-port monitoring.
module tb_nibble_serial_adder;

  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  int checks_total;
  int checks_passed;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // External 4-bit ripple adder
  always_comb {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Reference: integer arithmetic on the operands as written by the user
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                       input logic msub, output logic [W-1:0] rs, output logic rc,
                       output logic ro);
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    if (msub) begin
      ures = ua - ub;
      sres = sa - sb;
      rc   = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(mcin);
      sres = sa + sb + longint'(mcin);
      rc   = (ures >= 65536);
    end
    rs = W'(ures & 65535);
    ro = (sres > 32767) || (sres < -32768);
  endtask

  // Full operation starting at a negedge; holds DONE for `hold` cycles and
  // optionally presents a competing request during RUN/DONE.
  task automatic do_op(input vec_t v, input int hold, input bit intrude, input string nm);
    logic [W-1:0] beff;
    logic         prev_c;
    beff = v.sub ? ~v.b : v.b;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    chk({nm, " in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = intrude;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    prev_c = v.sub ? 1'b1 : v.cin;
    for (int i = 0; i < int'(N); i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("%s add_a[%0d]", nm, i), 32'(add_a), 32'(v.a[4*i +: 4]));
      chk($sformatf("%s add_b[%0d]", nm, i), 32'(add_b), 32'(beff[4*i +: 4]));
      chk($sformatf("%s add_cin[%0d]", nm, i), 32'(add_cin), 32'(prev_c));
      chk($sformatf("%s out_valid_run[%0d]", nm, i), 32'(out_valid), 32'd0);
      prev_c = add_cout;
    end
    @(negedge clk);
    for (int k = 0; k <= hold; k++) begin
      chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " in_ready_done"}, 32'(in_ready), 32'd0);
      chk({nm, " sum"}, 32'(sum), 32'(v.exp_sum));
      chk({nm, " cout"}, 32'(cout), 32'(v.exp_cout));
      chk({nm, " ovf"}, 32'(ovf), 32'(v.exp_ovf));
      chk({nm, " add_a_done"}, 32'({add_a, add_b, add_cin}), 32'd0);
      if (k < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " out_valid_released"}, 32'(out_valid), 32'd0);
    chk({nm, " in_ready_back"}, 32'(in_ready), 32'd1);
    chk({nm, " sum_held_idle"}, 32'(sum), 32'(v.exp_sum));
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    checks_total = 0; checks_passed = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};

    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset cout_ovf", 32'({cout, ovf}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));

    // Backpressure with a competing request that must be ignored
    do_op(vecs[0], 5, 1'b1, "bp");

    // Reset after two RUN cycles aborts the operation
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid sum", 32'(sum), 32'd0);
    chk("rst_mid cout_ovf", 32'({cout, ovf}), 32'd0);
    chk("rst_mid adder", 32'({add_a, add_b, add_cin}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    do_op(v, 0, 1'b0, "post_rst");

    // Randomized operations against the reference model
    for (int r = 0; r < 40; r++) begin
      v.a   = W'($urandom);
      v.b   = (r % 8 == 0) ? v.a : W'($urandom);
      v.cin = 1'($urandom);
      v.sub = 1'($urandom);
      model(v.a, v.b, v.cin, v.sub, v.exp_sum, v.exp_cout, v.exp_ovf);
      do_op(v, int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
